moving_average_mc: RTL and testbench
====================================

# moving_average_mc

Multi-channel, time-multiplexed boxcar moving-average filter for the PCM path after PDM decimation. It keeps a running sum per channel, adding each new sample and subtracting the oldest one, so any window length costs one adder pair instead of a full tap sum. It adds valid/ready back-pressure, per-channel window-full status, selectable rounding and a synchronous clear.

## Interface
- DATA_WIDTH, 16: signed sample width, in and out.
- LOG2_TAPS, 6: window length is TAPS = 2^LOG2_TAPS; legal range 1..10.
- NUM_CH, 2: number of independent channels; legal range ≥1.
- ROUND, 1: 0 = floor (arithmetic shift); 1 = round half toward +inf.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of all channel state.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept.
- in_channel  in  max(1,$clog2(NUM_CH))  channel tag of the sample.
- in_sample  in  DATA_WIDTH  signed sample.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_channel  out  as in_channel  channel tag of the result.
- out_sample  out  DATA_WIDTH  signed window average.
- out_full  out  1  window of out_channel had TAPS samples, including this one.
- err_chan  out  1  sticky: a sample arrived with in_channel ≥ NUM_CH.

## Operation
- Per channel state:
  - circular buffer of TAPS samples;
  - write pointer (LOG2_TAPS bits, wraps naturally);
  - running sum of ACC_W = DATA_WIDTH+LOG2_TAPS bits, signed;
  - fill counter that saturates at TAPS.
- On accept (in_valid && in_ready) with a valid channel c:
  - old = buf[c][ptr[c]];
  - sum' = sum[c] + sext(in_sample) − sext(old);
  - buf[c][ptr[c]] ← in_sample; ptr[c] ← ptr[c]+1; sum[c] ← sum'; fill[c] ← min(fill+1, TAPS).
- Output value:
  - ROUND=0: out_sample = sum' >>> LOG2_TAPS.
  - ROUND=1: out_sample = (sum' + 2^(LOG2_TAPS−1)) >>> LOG2_TAPS, computed at ACC_W+1 bits.
  - The result always fits DATA_WIDTH, so no saturation is needed.
- Before the window fills, empty slots count as zero. The average is still divided by TAPS, and out_full=0.
- Invalid channel (≥ NUM_CH, only possible when NUM_CH is not a power of two): the sample is consumed, no state changes, no output is produced, and err_chan is set.
- clear, in one cycle:
  - zeroes all buffers, sums, pointers and fill counters, and err_chan;
  - in_ready=0 that cycle, so a concurrent in_valid is not accepted;
  - a pending output is not disturbed.

## Timing
- Reset: out_valid=0, out_sample=0, out_channel=0, out_full=0, err_chan=0, and all state is zero. in_ready=0 while rst_n is low.
- in_ready = !clear && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
- Latency is 1 cycle. The result of a sample accepted at edge N is presented with out_valid=1 after edge N.
- Output stability:
  - out_* stay stable while out_valid && !out_ready.
  - The output register reloads on any edge that accepts a valid-channel sample.
  - The output register clears out_valid on an out_ready edge with no new accept.
- Back-to-back throughput is 1 sample/cycle, including consecutive samples on the same channel.
- An asynchronous reset mid-stream discards all state and any pending output immediately.

## Structure
- Package moving_average_pkg holds:
  - function acc_width(DATA_WIDTH, LOG2_TAPS);
  - function ch_width(NUM_CH);
  - the rounding constant.
- Sub-module ma_delay_line holds one channel's circular buffer, pointer and fill counter. It exposes old-sample read, write and clear, and is instantiated NUM_CH times via generate. The top level muxes ma_delay_line by channel and owns the sums, arithmetic, output register and handshake.

## Test plan
All scenarios use DATA_WIDTH=16, LOG2_TAPS=2, NUM_CH=2 unless stated.
- Step, ROUND=0: ch0 gets 100 ×5. Outputs are 25, 50, 75, 100, 100; out_full is 0, 0, 0, 1, 1.
- Rounding on ch0, each case from a fresh reset:
  - single −1: ROUND=0 gives −1, ROUND=1 gives 0;
  - single 2 with ROUND=1: (2+2)>>>2 = 1.
- Interleave: alternate ch0=40 and ch1=−40 for 8 samples. out_channel alternates; values are ±10, ±20, ±30, ±40, ±40, … with no cross-talk.
- Back-pressure: hold out_ready=0 after one output. in_ready drops and out_* hold. Release it: the next sample is accepted that edge with no loss or duplication.
- Extremes: 32767 ×4 gives 32767 (both ROUND); −32768 ×4 gives −32768; then 0 ×4 decays to −24576, −16384, −8192, 0.
- Clear and error, NUM_CH=3: in_channel=3 sets err_chan with no out_valid. clear mid-window with in_valid high: sample dropped, err_chan=0. Next 8 on ch0 gives 2 (out_full=0).

Source files
------------

// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the multi-channel boxcar averager.
// Widths and the rounding bias are derived here so all files agree.
package moving_average_pkg;

  function automatic int acc_width(input int data_width,
                                   input int log2_taps);
    return data_width + log2_taps;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int round_const(input int log2_taps,
                                     input int round);
    return (round != 0) ? (1 << (log2_taps - 1)) : 0;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// One channel's sample history: circular buffer, write pointer
// and saturating fill counter.
module ma_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_TAPS  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] old_sample,
  output logic                         full_next
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] FILL_MAX  = (LOG2_TAPS+1)'(TAPS);
  localparam logic [LOG2_TAPS:0] FILL_LAST = (LOG2_TAPS+1)'(TAPS-1);

  logic signed [DATA_WIDTH-1:0] mem [TAPS];
  logic [LOG2_TAPS-1:0]         ptr;
  logic [LOG2_TAPS:0]           fill;

  assign old_sample = mem[ptr];
  // True when the sample being written completes the window.
  assign full_next  = (fill >= FILL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      ptr  <= '0;
      fill <= '0;
    end else if (wr_en) begin
      mem[ptr] <= wr_data;
      ptr      <= ptr + 1'b1;
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/moving_average_mc.sv
// Time-multiplexed boxcar averager: per-channel running sums,
// one add/subtract pair, registered output with valid/ready.
module moving_average_mc
  import moving_average_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_TAPS  = 6,
  parameter int NUM_CH     = 2,
  parameter int ROUND      = 1,
  localparam int CW        = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CW-1:0]                in_channel,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CW-1:0]                out_channel,
  output logic signed [DATA_WIDTH-1:0] out_sample,
  output logic                         out_full,
  output logic                         err_chan
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_TAPS);
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'(round_const(LOG2_TAPS, ROUND));

  logic signed [DATA_WIDTH-1:0] old_arr [NUM_CH];
  logic [NUM_CH-1:0]            full_arr;
  logic [NUM_CH-1:0]            wr_en;
  logic signed [ACC_W-1:0]      sum_q [NUM_CH];

  logic                         accept;
  logic                         chan_ok;
  logic signed [DATA_WIDTH-1:0] old_sel;
  logic signed [ACC_W-1:0]      sum_sel;
  logic                         full_sel;
  logic signed [ACC_W-1:0]      sum_next;
  logic signed [ACC_W:0]        sum_rnd;
  logic signed [ACC_W:0]        avg;
  logic                         unused;

  assign in_ready = rst_n && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign chan_ok  = (32'(in_channel) < 32'(NUM_CH));

  always_comb begin
    old_sel  = '0;
    sum_sel  = '0;
    full_sel = 1'b0;
    wr_en    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(in_channel) == 32'(i)) begin
        old_sel  = old_arr[i];
        sum_sel  = sum_q[i];
        full_sel = full_arr[i];
        wr_en[i] = accept;
      end
    end
  end

  assign sum_next = sum_sel
    + $signed({{LOG2_TAPS{in_sample[DATA_WIDTH-1]}}, in_sample})
    - $signed({{LOG2_TAPS{old_sel[DATA_WIDTH-1]}}, old_sel});

  // One extra bit keeps the rounding bias from wrapping at full scale.
  assign sum_rnd = $signed({sum_next[ACC_W-1], sum_next}) + RND;
  assign avg     = sum_rnd >>> LOG2_TAPS;
  assign unused  = ^{avg[ACC_W:DATA_WIDTH], sum_rnd[LOG2_TAPS-1:0]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ma_delay_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .LOG2_TAPS (LOG2_TAPS)
    ) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .wr_en     (wr_en[g]),
      .wr_data   (in_sample),
      .old_sample(old_arr[g]),
      .full_next (full_arr[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) sum_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) sum_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en[i]) sum_q[i] <= sum_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_sample  <= '0;
      out_full    <= 1'b0;
    end else if (accept && chan_ok) begin
      out_valid   <= 1'b1;
      out_channel <= in_channel;
      out_sample  <= avg[DATA_WIDTH-1:0];
      out_full    <= full_sel;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_chan <= 1'b0;
    else if (clear)               err_chan <= 1'b0;
    else if (accept && !chan_ok)  err_chan <= 1'b1;
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// Scoreboard bench: floor and round-half-up instances share stimulus,
// a negedge monitor pops expected results on each output handshake.
module tb_moving_average_mc;

  localparam int DW  = 16;
  localparam int L   = 2;
  localparam int NCH = 3;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [CW-1:0] in_channel = '0;
  logic signed [DW-1:0] in_sample = '0;

  logic in_ready0, in_ready1;
  logic out_valid0, out_valid1;
  logic out_full0, out_full1;
  logic err0, err1;
  logic [CW-1:0] out_ch0, out_ch1;
  logic signed [DW-1:0] out_s0, out_s1;

  typedef struct {
    int ch;
    int v0;
    int v1;
    int full;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  moving_average_mc #(
    .DATA_WIDTH(DW), .LOG2_TAPS(L), .NUM_CH(NCH), .ROUND(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_channel(in_channel), .in_sample(in_sample),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_channel(out_ch0), .out_sample(out_s0),
    .out_full(out_full0), .err_chan(err0)
  );

  moving_average_mc #(
    .DATA_WIDTH(DW), .LOG2_TAPS(L), .NUM_CH(NCH), .ROUND(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_channel(in_channel), .in_sample(in_sample),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_channel(out_ch1), .out_sample(out_s1),
    .out_full(out_full1), .err_chan(err1)
  );

  task automatic check(input string name, input int act,
                       input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (out_valid0 || out_valid1) && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected output", 1, 0);
      end else begin
        e = q.pop_front();
        check("valid r0", int'(out_valid0), 1);
        check("valid r1", int'(out_valid1), 1);
        check("chan r0", int'(out_ch0), e.ch);
        check("chan r1", int'(out_ch1), e.ch);
        check("avg r0", int'(out_s0), e.v0);
        check("avg r1", int'(out_s1), e.v1);
        check("full r0", int'(out_full0), e.full);
        check("full r1", int'(out_full1), e.full);
      end
    end
  end

  task automatic send(input int ch, input int s, input int e0,
                      input int e1, input int full);
    int n;
    if (ch < NCH) q.push_back('{ch, e0, e1, full});
    in_valid   = 1'b1;
    in_channel = CW'(ch);
    in_sample  = DW'(s);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready0 || n >= 50) break;
      n++;
    end
    if (n >= 50) check("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    check("queue drained", q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("reset in_ready", int'(in_ready0 | in_ready1), 0);
    check("reset out_valid", int'(out_valid0 | out_valid1), 0);
    check("reset out_sample", int'(out_s0 | out_s1), 0);
    check("reset out_chan", int'(out_ch0 | out_ch1), 0);
    check("reset out_full", int'(out_full0 | out_full1), 0);
    check("reset err_chan", int'(err0 | err1), 0);
    q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // step response
    send(0, 100, 25, 25, 0);
    send(0, 100, 50, 50, 0);
    send(0, 100, 75, 75, 0);
    send(0, 100, 100, 100, 1);
    send(0, 100, 100, 100, 1);
    drain();

    // rounding
    do_reset();
    send(0, -1, -1, 0, 0);
    drain();
    do_reset();
    send(0, 2, 0, 1, 0);
    drain();

    // interleaved channels
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      send(0, 40, 10 * k, 10 * k, int'(k == 4));
      send(1, -40, -10 * k, -10 * k, int'(k == 4));
    end
    drain();

    // back-pressure
    do_reset();
    send(0, 100, 25, 25, 0);
    out_ready = 1'b0;
    fork
      send(0, 100, 50, 50, 0);
      begin
        repeat (2) begin
          @(posedge clk);
          #2;
          check("bp in_ready", int'(in_ready0), 0);
          check("bp out_valid", int'(out_valid0), 1);
          check("bp out_sample", int'(out_s0), 25);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // bad channel, clear mid-window
    do_reset();
    send(3, 77, 0, 0, 0);
    check("err_chan set r0", int'(err0), 1);
    check("err_chan set r1", int'(err1), 1);
    check("bad chan no out", int'(out_valid0), 0);
    send(0, 100, 25, 25, 0);
    send(0, 100, 50, 50, 0);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_channel = '0;
    in_sample  = 16'sd555;
    #1;
    check("clear in_ready", int'(in_ready0), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear err_chan", int'(err0 | err1), 0);
    send(0, 8, 2, 2, 0);
    drain();

    // extremes
    do_reset();
    send(1, 32767, 8191, 8192, 0);
    send(1, 32767, 16383, 16384, 0);
    send(1, 32767, 24575, 24575, 0);
    send(1, 32767, 32767, 32767, 1);
    send(1, -32768, 16383, 16383, 1);
    send(1, -32768, -1, 0, 1);
    send(1, -32768, -16385, -16384, 1);
    send(1, -32768, -32768, -32768, 1);
    send(1, 0, -24576, -24576, 1);
    send(1, 0, -16384, -16384, 1);
    send(1, 0, -8192, -8192, 1);
    send(1, 0, 0, 0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
